// File: rtl/mips_pkg.sv
// mips_pkg: FSM encodings, reset PC and opcode constants shared across the core.
package mips_pkg;
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J = 6'b000010;
    localparam logic [5:0] OP_JAL = 6'b000011;
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory req/ack bus between fetch unit and memory.
interface pc_fetch_unit_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;
    modport master(output im_req, im_addr, input im_ack, im_rdata);
    modport slave(input im_req, im_addr, output im_ack, im_rdata);
endinterface

// File: rtl/pc_fetch_unit_fsm.sv
// ifu_fsm: BOOT/FETCH/HOLD sequencing, request and instr_valid generation.
module ifu_fsm
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic pc_change,
    input  logic stall,
    input  logic im_ack,
    output logic im_req,
    output logic instr_valid,
    output logic capture,
    output logic complete,
    output logic load,
    output logic proto_err
);
    logic [1:0] state, state_nx;
    logic done;
    always_comb begin
        im_req    = state == FETCH && !done;
        capture   = im_req && im_ack;
        // a word captured under stall completes once stall drops
        complete  = state == FETCH && !stall && (capture || done);
        load      = state == HOLD && pc_change && !stall;
        proto_err = (state == FETCH && pc_change) || (im_ack && !im_req);
        state_nx  = state == BOOT ? FETCH :
                    complete ? HOLD :
                    load ? FETCH :
                    (state == FETCH || state == HOLD) ? state : BOOT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            done        <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nx;
            done        <= state == FETCH && !complete && (done || capture);
            instr_valid <= complete ? 1'b1 : load ? 1'b0 : instr_valid;
        end
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC, instruction latch and fetch counter around ifu_fsm.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_change,
    input  logic [31:0]       npc,
    input  logic              stall,
    pc_fetch_unit_if.master   im,
    output logic [31:0]       pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              err
);
    logic capture, complete, load, proto_err;
    ifu_fsm u_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_change  (pc_change),
        .stall      (stall),
        .im_ack     (im.im_ack),
        .im_req     (im.im_req),
        .instr_valid(instr_valid),
        .capture    (capture),
        .complete   (complete),
        .load       (load),
        .proto_err  (proto_err)
    );
    assign im.im_addr = pc;
    assign opcode = instr[31:26];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            instr     <= '0;
            fetch_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (load) pc <= word_align(npc);
            if (capture) instr <= im.im_rdata;
            if (complete) fetch_cnt <= fetch_cnt + 1'b1;
            err <= err | proto_err | (load && |npc[1:0]);
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, corner-case sequences and a randomized run against a behavioural model.
module tb_pc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_change = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] npc = '0;
    logic [31:0] pc, instr, fetch_cnt;
    logic [5:0]  opcode;
    logic        instr_valid, err;
    int n_tests = 0;
    int n_fail = 0;

    pc_fetch_unit_if im();

    pc_fetch_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_change  (pc_change),
        .npc        (npc),
        .stall      (stall),
        .im         (im),
        .pc         (pc),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .fetch_cnt  (fetch_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pcc;
        logic [31:0] npc;
        logic        stall;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic [31:0] e_cnt;
        logic        e_err;
    } vec_t;

    typedef enum {M_BOOT, M_FETCH, M_HOLD} mphase_t;

    function automatic logic [159:0] pack(input logic req, input logic [31:0] p, input logic [31:0] ins,
                                          input logic v, input logic [31:0] c, input logic e);
        logic [31:0] t;
        t = ins;
        return {23'd0, req, p, p, ins, t[31:26], v, c, e};
    endfunction

    function automatic logic [159:0] snap();
        return {23'd0, im.im_req, im.im_addr, pc, instr, opcode, instr_valid, fetch_cnt, err};
    endfunction

    task automatic check(input string name, input logic [159:0] exp);
        logic [159:0] act;
        act = snap();
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pcc, input logic [31:0] n, input logic st, input logic ack, input logic [31:0] rd);
        pc_change = pcc;
        npc = n;
        stall = st;
        im.im_ack = ack;
        im.im_rdata = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        check("reset_state", pack(0, 32'h3000, 0, 0, 0, 0));
        step();
        rst_n = 1'b1;
    endtask

    vec_t tbl[15];

    // behavioural model state
    mphase_t m_phase;
    logic    m_wait, m_valid, m_err;
    logic [31:0] m_pc, m_instr, m_cnt;

    initial begin
        im.im_ack = 1'b0;
        im.im_rdata = '0;
        tbl[0]  = '{0, 0, 0, 1, 32'h2008_0005, 1, 32'h3000, 32'h0, 0, 0, 1};
        tbl[1]  = '{0, 0, 0, 1, 32'h2008_0005, 0, 32'h3000, 32'h2008_0005, 1, 1, 1};
        tbl[2]  = '{1, 32'h3010, 0, 0, 0, 1, 32'h3010, 32'h2008_0005, 0, 1, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 32'h3010, 32'h2008_0005, 0, 1, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 1, 32'h3010, 32'h2008_0005, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 32'h3010, 32'h2008_0005, 0, 1, 1};
        tbl[6]  = '{0, 0, 0, 1, 32'h8c22_0004, 0, 32'h3010, 32'h8c22_0004, 1, 2, 1};
        tbl[7]  = '{1, 32'h3006, 0, 0, 0, 1, 32'h3004, 32'h8c22_0004, 0, 2, 1};
        tbl[8]  = '{0, 0, 1, 1, 32'h0, 0, 32'h3004, 32'h0, 0, 2, 1};
        tbl[9]  = '{0, 0, 1, 0, 0, 0, 32'h3004, 32'h0, 0, 2, 1};
        tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h3004, 32'h0, 1, 3, 1};
        tbl[11] = '{1, 32'h3020, 0, 0, 0, 1, 32'h3020, 32'h0, 0, 3, 1};
        tbl[12] = '{1, 32'h4000, 0, 0, 0, 1, 32'h3020, 32'h0, 0, 3, 1};
        tbl[13] = '{0, 0, 0, 1, 32'h0c00_0c00, 0, 32'h3020, 32'h0c00_0c00, 1, 4, 1};
        tbl[14] = '{1, 32'h5000, 1, 0, 0, 0, 32'h3020, 32'h0c00_0c00, 1, 4, 1};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].pcc, tbl[i].npc, tbl[i].stall, tbl[i].ack, tbl[i].rdata);
            step();
            check($sformatf("vec%0d", i), pack(tbl[i].e_req, tbl[i].e_pc, tbl[i].e_instr,
                                               tbl[i].e_valid, tbl[i].e_cnt, tbl[i].e_err));
        end

        // pc_change during FETCH is discarded and flagged
        do_reset();
        drive(0, 0, 0, 0, 0); step();
        check("boot_to_fetch", pack(1, 32'h3000, 0, 0, 0, 0));
        drive(1, 32'h4000, 0, 0, 0); step();
        check("pcc_in_fetch", pack(1, 32'h3000, 0, 0, 0, 1));
        drive(0, 0, 0, 1, 32'h0043_0820); step();
        check("fetch_after_pcc", pack(0, 32'h3000, 32'h0043_0820, 1, 1, 1));

        // misaligned npc sets err from a clean state
        do_reset();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 32'h1111_1111); step();
        check("clean_hold", pack(0, 32'h3000, 32'h1111_1111, 1, 1, 0));
        drive(1, 32'h3006, 0, 0, 0); step();
        check("misaligned_npc", pack(1, 32'h3004, 32'h1111_1111, 0, 1, 1));

        // spurious ack in HOLD is ignored but flagged
        do_reset();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 32'h2222_2222); step();
        drive(0, 0, 0, 1, 32'h3333_3333); step();
        check("ack_in_hold", pack(0, 32'h3000, 32'h2222_2222, 1, 1, 1));

        // asynchronous reset mid-fetch, then stray ack in BOOT
        do_reset();
        drive(0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 32'h4444_4444); step();
        drive(1, 32'h3100, 0, 0, 0); step();
        check("refetch", pack(1, 32'h3100, 32'h4444_4444, 0, 1, 0));
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset", pack(0, 32'h3000, 0, 0, 0, 0));
        step();
        rst_n = 1'b1;
        drive(0, 0, 0, 1, 32'h5555_5555); step();
        check("stray_ack_boot", pack(1, 32'h3000, 0, 0, 0, 1));

        // randomized run against the model
        do_reset();
        m_phase = M_BOOT; m_wait = 0; m_valid = 0; m_err = 0;
        m_pc = 32'h3000; m_instr = 0; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic pcc, st, ack, req_now;
            logic [31:0] n, rd;
            pcc = $urandom_range(0, 5) == 0;
            st  = $urandom_range(0, 3) == 0;
            ack = $urandom_range(0, 2) == 0;
            n   = $urandom();
            if ($urandom_range(0, 3) != 0) n[1:0] = 2'b00;
            rd  = $urandom();
            drive(pcc, n, st, ack, rd);
            req_now = m_phase == M_FETCH && m_wait;
            if (ack && !req_now) m_err = 1;
            if (m_phase == M_BOOT) begin
                m_phase = M_FETCH;
                m_wait = 1;
            end else if (m_phase == M_FETCH) begin
                if (pcc) m_err = 1;
                if (req_now && ack) begin
                    m_instr = rd;
                    m_wait = 0;
                end
                if (!m_wait && !st) begin
                    m_valid = 1;
                    m_cnt = m_cnt + 1;
                    m_phase = M_HOLD;
                end
            end else if (pcc && !st) begin
                m_pc = n & 32'hffff_fffc;
                if (n[1:0] != 0) m_err = 1;
                m_valid = 0;
                m_phase = M_FETCH;
                m_wait = 1;
            end
            step();
            check($sformatf("rand%0d", c), pack(m_phase == M_FETCH && m_wait, m_pc, m_instr, m_valid, m_cnt, m_err));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the architectural PC register and fetches instructions from instruction memory over a req/ack handshake.
- Presents the current pc and the fetched instruction word to the next-PC logic and the decoder.
- Loads the next-PC value the next-PC logic computes when the core signals a PC change.
- Sits between the instruction memory and the next-PC/decode stage of the multicycle MIPS core.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- pc_change  input  1  one-cycle pulse: load npc into pc and start the next fetch.
- npc  input  32  next PC from the next-PC logic.
- stall  input  1  holds the unit in its current state, suppressing new requests.
- im_req  output  1  instruction-memory request.
- im_addr  output  32  word address to instruction memory (equals pc).
- im_ack  input  1  memory response valid; im_rdata is sampled on this cycle.
- im_rdata  input  32  instruction word from memory.
- pc  output  32  current PC.
- instr  output  32  latched instruction word.
- opcode  output  6  instr[31:26].
- instr_valid  output  1  instr holds the word fetched from the current pc.
- fetch_cnt  output  CNT_W  number of completed fetches.
- err  output  1  sticky protocol/alignment error.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC, instr = 0, instr_valid = 0, im_req = 0, fetch_cnt = 0, err = 0.
  - State = BOOT.
- FSM states: BOOT, FETCH, HOLD.
- BOOT:
  - Lasts exactly one cycle after reset release, then moves to FETCH.
  - pc_change is ignored in BOOT.
- FETCH:
  - im_req = 1 and im_addr = pc, stable until ack.
  - On im_ack: instr <= im_rdata, instr_valid <= 1, fetch_cnt += 1 (wraps modulo 2^CNT_W), im_req drops the next cycle, move to HOLD.
  - Minimum latency from request to instr_valid: 1 cycle after the ack cycle.
  - An ack arriving in the same cycle im_req first rises is legal.
- HOLD:
  - im_req = 0; instr, pc and instr_valid are held.
  - On pc_change: pc <= npc, instr_valid <= 0, move to FETCH. The new request appears the cycle after the pulse.
- stall:
  - When high, the state does not advance and pc is not loaded.
  - In FETCH with a request outstanding, im_req stays high and im_ack is still captured; the transition to HOLD is deferred until stall drops. The captured word is kept.
  - stall has no effect in BOOT.
- Error conditions (err sets sticky until reset; unit continues):
  - pc_change in FETCH: the pulse is discarded, pc is unchanged, err <= 1.
  - npc[1:0] != 0 on pc_change in HOLD: pc <= {npc[31:2],2'b00}, err <= 1.
  - im_ack while im_req is low: ignored, err <= 1.
- Simultaneous pc_change and stall in HOLD: stall wins and the pulse is lost. The core must not pulse pc_change while stall is high.
- Reset mid-fetch: the request drops immediately and asynchronously; pc returns to RESET_PC. A memory ack arriving after reset release is treated as a spurious ack.
- opcode is combinational from instr.
- pc is always word aligned.

Decomposition:
- Shared package mips_pkg holds:
  - the FSM state encoding localparams (BOOT=2'd0, FETCH=2'd1, HOLD=2'd2);
  - RESET_PC default;
  - opcode constants (OP_RTYPE=6'b000000, OP_REGIMM=6'b000001, OP_BEQ=6'b000100, OP_J=6'b000010, OP_JAL=6'b000011), shared with the next-PC logic and decoder.
- One sub-module is natural: ifu_fsm, holding the state register, next-state logic and req/valid generation. The pc, instr and counter datapath stays in the top.

Test Plan:
- Reset release with im_ack tied high:
  - im_req rises on the 2nd cycle with im_addr = 32'h0000_3000.
  - im_rdata = 32'h2008_0005 gives instr = 32'h2008_0005, opcode = 6'b001000, instr_valid = 1, fetch_cnt = 1.
- In HOLD, pulse pc_change with npc = 32'h0000_3010:
  - next cycle pc = 32'h0000_3010, instr_valid = 0, im_req = 1;
  - ack after 3 wait cycles gives instr_valid = 1, fetch_cnt = 2.
- pc_change during FETCH with npc = 32'h0000_4000:
  - pc stays 32'h0000_3000 and err = 1;
  - the fetch completes normally.
- npc = 32'h0000_3006 on pc_change in HOLD: pc = 32'h0000_3004 and err = 1.
- stall high across the ack cycle:
  - instr is captured but the state stays FETCH;
  - on stall low, HOLD is entered next cycle and fetch_cnt increments once.
- rst_n asserted while im_req = 1:
  - im_req = 0 immediately, pc = 32'h0000_3000, fetch_cnt = 0;
  - a stray im_ack in BOOT sets err = 1.
